// File: rtl/button_debouncer.sv
// Per-channel synchronizer + stability-count debouncer with registered rise/fall pulses.
// Optional BUTTON_DEBOUNCER_TOGGLE_EN adds a toggle output flipped on every accepted rise.
module button_debouncer #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    ,
    output logic [WIDTH-1:0] toggle
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_debouncer: DEBOUNCE_CYCLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_debouncer: SYNC_STAGES must be >= 2");
    end

    // STABLE: synchronized level agrees with q. PENDING: a new level is being timed.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic [CW-1:0]          cnt_r;
        logic                   s;
        logic                   q_r;
        logic                   rise_r;
        logic                   fall_r;
        state_e                 state;

        assign s     = sync_r[SYNC_STAGES-1];
        assign state = (s != q_r) ? ST_PENDING : ST_STABLE;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_r <= '0;
                cnt_r  <= '0;
                q_r    <= 1'b0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], raw[i]};
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                case (state)
                    ST_STABLE: begin
                        // A glitch that returned to q lands here and discards its count.
                        cnt_r <= '0;
                    end
                    ST_PENDING: begin
                        if (cnt_r == LAST) begin
                            q_r    <= s;
                            cnt_r  <= '0;
                            rise_r <= s;
                            fall_r <= ~s;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                    default: cnt_r <= '0;
                endcase
            end
        end

        assign q[i]    = q_r;
        assign rise[i] = rise_r;
        assign fall[i] = fall_r;

`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
        logic toggle_r;

        // Flips on the same edge that launches the rise pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                toggle_r <= 1'b0;
            end else if (state == ST_PENDING && cnt_r == LAST && s) begin
                toggle_r <= ~toggle_r;
            end
        end

        assign toggle[i] = toggle_r;
`endif
    end

endmodule
